// File: rtl/qtcore_scan_master.sv
// qtcore_scan_master: bit-serial scan-chain initiator for the qtcore A1 scan
// interface. It exchanges a full chain image with the core and can run the
// core until it halts or a cycle budget expires.
// Optional feature macro: QTCORE_SCAN_MASTER_RUN_EN (RUN / GAP2 / SHIFT2 path).
`timescale 1ns/1ps
module qtcore_scan_master #(
  parameter int unsigned CHAIN_LEN = 168,
  parameter int unsigned RUN_W     = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic [1:0]           mode_in,
  input  logic [CHAIN_LEN-1:0] chain_in,
  input  logic [RUN_W-1:0]     max_cycles_in,
  input  logic                 scan_data_in,
  output logic                 scan_en_out,
  output logic                 scan_data_out,
  output logic                 proc_en_out,
  output logic [CHAIN_LEN-1:0] chain_out,
  output logic [RUN_W-1:0]     cycles_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 halted_out
);

  localparam int unsigned BIT_W = $clog2(CHAIN_LEN);
`ifdef QTCORE_SCAN_MASTER_RUN_EN
  localparam bit RUN_EN = 1'b1;
`else
  localparam bit RUN_EN = 1'b0;
`endif

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_XRX  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT1 = 3'd1,
    GAP1   = 3'd2,
    RUN    = 3'd3,
    GAP2   = 3'd4,
    SHIFT2 = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] shreg_q;
  logic [1:0]           mode_q;
  logic [RUN_W-1:0]     budget_q;
  logic [RUN_W-1:0]     run_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [RUN_W-1:0]     cycles_q;
  logic                 halted_q;
  logic                 scan_en_q, busy_q, done_q;

  logic shift_c, last_bit_c, run_exit_c, halt_hit_c, proc_en_c;
  logic scan_en_d, busy_d, done_d;

  // Next-state decode, run exit detection and registered-output precompute
  always_comb begin
    state_d    = state_q;
    shift_c    = 1'b0;
    run_exit_c = 1'b0;
    halt_hit_c = 1'b0;
    proc_en_c  = 1'b0;
    last_bit_c = (bit_cnt_q == BIT_W'(CHAIN_LEN - 1));
    case (state_q)
      IDLE: begin
        if (start_in) state_d = (RUN_EN && mode_in == MODE_RUN) ? RUN : SHIFT1;
      end
      SHIFT1: begin
        shift_c = 1'b1;
        if (last_bit_c) state_d = GAP1;
      end
      GAP1: begin
        state_d = (RUN_EN && mode_q == MODE_XRX) ? RUN : IDLE;
      end
      RUN: begin
        // halt line may still show a stale flag right after a load
        halt_hit_c = (run_cnt_q >= RUN_W'(4)) && scan_data_in;
        run_exit_c = (run_cnt_q == budget_q) || halt_hit_c;
        proc_en_c  = RUN_EN && !run_exit_c;
        if (run_exit_c) state_d = (mode_q == MODE_XRX) ? GAP2 : IDLE;
      end
      GAP2: begin
        state_d = SHIFT2;
      end
      SHIFT2: begin
        shift_c = 1'b1;
        if (last_bit_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d    = (state_d == IDLE) && (state_q != IDLE);
    busy_d    = (state_d != IDLE) || done_d;
    scan_en_d = (state_d == SHIFT1) || (state_d == SHIFT2);
  end

  // State register and glitch-free control outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      scan_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_en_q <= scan_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Command capture, chain shifting and run-cycle accounting
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shreg_q   <= '0;
      mode_q    <= '0;
      budget_q  <= '0;
      run_cnt_q <= '0;
      bit_cnt_q <= '0;
      cycles_q  <= '0;
      halted_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && start_in) begin
        shreg_q   <= chain_in;
        mode_q    <= mode_in;
        budget_q  <= max_cycles_in;
        run_cnt_q <= '0;
        bit_cnt_q <= '0;
        cycles_q  <= '0;
        halted_q  <= 1'b0;
      end
      if (shift_c) begin
        shreg_q   <= {shreg_q[CHAIN_LEN-2:0], scan_data_in};
        bit_cnt_q <= last_bit_c ? '0 : bit_cnt_q + BIT_W'(1);
      end
      if (state_q == RUN) begin
        if (run_exit_c) begin
          cycles_q <= run_cnt_q;
          halted_q <= halt_hit_c;
        end else begin
          run_cnt_q <= run_cnt_q + RUN_W'(1);
        end
      end
    end
  end

  assign scan_en_out   = scan_en_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign scan_data_out = shreg_q[CHAIN_LEN-1];
  assign chain_out     = shreg_q;
  assign proc_en_out   = proc_en_c;
  assign cycles_out    = RUN_EN ? cycles_q : '0;
  assign halted_out    = RUN_EN ? halted_q : 1'b0;

endmodule
